mmio_gpio_bank: RTL and testbench
=================================

MMIO_GPIO_BANK -- requirements
Module: mmio_gpio_bank

Interface
REQ-001 Parameter XLEN, default 32, data bus and register width.
REQ-002 Parameter IO_INPUT_BUS_LEN, default 14, number of input pins.
REQ-003 Parameter IO_OUTPUT_BUS_LEN, default 52, number of output pins.
REQ-004 Parameter IO_BASE_ADDR, default 'h15, word address of register offset 0.
REQ-005 clock  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-007 addr  in  XLEN  word address from the core's data-memory port.
REQ-008 wdata  in  XLEN  write data.
REQ-009 wen  in  1  write strobe, sampled at the rising clock edge.
REQ-010 ren  in  1  read strobe, combinational qualifier for rdata.
REQ-011 rdata  out  XLEN  read data, combinational, same cycle as addr/ren.
REQ-012 hit  out  1  high when addr lies in this block's register window.
REQ-013 io_input_bus  in  IO_INPUT_BUS_LEN  asynchronous external inputs.
REQ-014 io_output_bus  out  IO_OUTPUT_BUS_LEN  registered external outputs.
REQ-015 irq  out  1  level interrupt request.

Function
REQ-016 NOUT = ceil(IO_OUTPUT_BUS_LEN/XLEN) and NIN = ceil(IO_INPUT_BUS_LEN/XLEN) shall define the word counts.
REQ-017 Register map (offset from IO_BASE_ADDR): OUT[0..NOUT-1] RW; IN[0..NIN-1] RO; CAP[0..NIN-1] RW1C; MASK[0..NIN-1] RW; total window NOUT+3*NIN words.
REQ-018 Word k of each bank shall hold pin bits k*XLEN..k*XLEN+XLEN-1; bits beyond the pin count shall read 0 and ignore writes.
REQ-019 hit shall be 1 iff IO_BASE_ADDR <= addr < IO_BASE_ADDR+window; addr outside the window shall give hit=0, rdata=0, and no write effect.
REQ-020 rdata shall be 0 whenever ren=0 or hit=0.
REQ-021 Write to OUT word shall update io_output_bus bits at the same clock edge; io_output_bus driven directly from the register.
REQ-022 Writes to IN offsets shall be ignored.
REQ-023 Each input pin shall pass through a two-flop synchronizer (s1, s2); IN reads return s2.
REQ-024 A third flop prev shall hold the previous s2; rise = s2 & ~prev.
REQ-025 CAP bit shall set on the edge where rise=1 and stay set until cleared by writing 1 to it; writing 0 shall have no effect.
REQ-026 Simultaneous W1C and rise on the same bit in the same cycle: bit shall end set (set wins).
REQ-027 irq = OR over all bits of (CAP & MASK), combinational from registers.
REQ-028 Latency: input rising at pin before edge 1 -> IN reads 1 after edge 2 -> CAP bit and irq (if masked in) high after edge 3.
REQ-029 Input pulses shorter than one clock period are not guaranteed to be captured.
REQ-030 Falling edges shall never set CAP.

Reset
REQ-031 On reset assertion, OUT, MASK, CAP, s1, s2, prev shall clear to 0 asynchronously; io_output_bus=0 and irq=0 immediately.
REQ-032 A write coinciding with reset shall have no effect; reset mid-capture shall discard pending synchronizer state.
REQ-033 After reset deassertion, an input held high shall produce one rise (prev starts 0) and set CAP after three edges.

Verification (defaults: OUT at 0x15-0x16, IN 0x17, CAP 0x18, MASK 0x19)
REQ-034 Write 0xDEADBEEF to 0x15, 0x000FFFFF to 0x16 -> io_output_bus = 52'hFFFFF_DEADBEEF; read 0x16 returns 0x000FFFFF; writing 0xFFFFFFFF to 0x16 reads back 0x000FFFFF.
REQ-035 Drive io_input_bus=14'h2A5 -> read 0x17 returns 0x000002A5 after two edges, 0 before; write 0xFFFF to 0x17 -> no change.
REQ-036 MASK=0x0001, raise pin 0 -> CAP[0]=1 and irq=1 after edge 3; write 0x1 to 0x18 -> CAP=0, irq=0 next cycle; raise pin 1 with MASK=1 -> CAP[1]=1, irq stays 0.
REQ-037 Hold pin 0 rising in the same cycle as W1C to CAP[0] -> CAP[0] remains 1.
REQ-038 Read addr 0x14 and 0x1A -> hit=0, rdata=0; write to them -> no register changes.
REQ-039 Assert reset mid-operation with OUT, MASK, CAP nonzero -> io_output_bus=0, irq=0 without clock edge; all reads return 0 after release.

Source files
------------

// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank: OUT (RW), IN (RO, 2-flop synced), CAP (RW1C rising-edge capture), MASK (RW), level irq.
// Latency: reads combinational, writes on the next edge, pin to CAP three edges; no backpressure, every access completes in one cycle.
module mmio_gpio_bank #(
  parameter int XLEN              = 32,
  parameter int IO_INPUT_BUS_LEN  = 14,
  parameter int IO_OUTPUT_BUS_LEN = 52,
  parameter int IO_BASE_ADDR      = 'h15
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [XLEN-1:0]              addr,
  input  logic [XLEN-1:0]              wdata,
  input  logic                         wen,
  input  logic                         ren,
  output logic [XLEN-1:0]              rdata,
  output logic                         hit,
  input  logic [IO_INPUT_BUS_LEN-1:0]  io_input_bus,
  output logic [IO_OUTPUT_BUS_LEN-1:0] io_output_bus,
  output logic                         irq
);

  localparam int NOUT     = (IO_OUTPUT_BUS_LEN + XLEN - 1) / XLEN;
  localparam int NIN      = (IO_INPUT_BUS_LEN + XLEN - 1) / XLEN;
  localparam int WIN      = NOUT + 3 * NIN;
  localparam int IN_OFF   = NOUT;
  localparam int CAP_OFF  = NOUT + NIN;
  localparam int MASK_OFF = NOUT + 2 * NIN;

  localparam logic [XLEN-1:0] BASE  = XLEN'(IO_BASE_ADDR);
  localparam logic [XLEN-1:0] LIMIT = XLEN'(IO_BASE_ADDR + WIN);

  logic [IO_OUTPUT_BUS_LEN-1:0] out_q, out_nxt;
  logic [IO_INPUT_BUS_LEN-1:0]  mask_q, mask_nxt;
  logic [IO_INPUT_BUS_LEN-1:0]  cap_q, cap_clr;
  logic [IO_INPUT_BUS_LEN-1:0]  s1_q, s2_q, prev_q;
  logic [IO_INPUT_BUS_LEN-1:0]  rise;

  assign hit  = (addr >= BASE) && (addr < LIMIT);
  assign rise = s2_q & ~prev_q;

  // Per-pin decode: pin i lives in word i/XLEN, bit i%XLEN of its bank.
  always_comb begin
    out_nxt  = out_q;
    mask_nxt = mask_q;
    cap_clr  = '0;
    for (int i = 0; i < IO_OUTPUT_BUS_LEN; i++) begin
      if (wen && (addr == XLEN'(IO_BASE_ADDR + i / XLEN)))
        out_nxt[i] = wdata[i % XLEN];
    end
    for (int i = 0; i < IO_INPUT_BUS_LEN; i++) begin
      if (wen && (addr == XLEN'(IO_BASE_ADDR + MASK_OFF + i / XLEN)))
        mask_nxt[i] = wdata[i % XLEN];
      if (wen && (addr == XLEN'(IO_BASE_ADDR + CAP_OFF + i / XLEN)))
        cap_clr[i] = wdata[i % XLEN];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      out_q  <= out_nxt;
      mask_q <= mask_nxt;
      // A rise on the same edge as a clear keeps the bit set.
      cap_q  <= (cap_q & ~cap_clr) | rise;
      s1_q   <= io_input_bus;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  always_comb begin
    rdata = '0;
    if (ren && hit) begin
      for (int i = 0; i < IO_OUTPUT_BUS_LEN; i++) begin
        if (addr == XLEN'(IO_BASE_ADDR + i / XLEN))
          rdata[i % XLEN] = out_q[i];
      end
      for (int i = 0; i < IO_INPUT_BUS_LEN; i++) begin
        if (addr == XLEN'(IO_BASE_ADDR + IN_OFF + i / XLEN))
          rdata[i % XLEN] = s2_q[i];
        if (addr == XLEN'(IO_BASE_ADDR + CAP_OFF + i / XLEN))
          rdata[i % XLEN] = cap_q[i];
        if (addr == XLEN'(IO_BASE_ADDR + MASK_OFF + i / XLEN))
          rdata[i % XLEN] = mask_q[i];
      end
    end
  end

  assign io_output_bus = out_q;
  assign irq           = |(cap_q & mask_q);

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Bench for mmio_gpio_bank: word-level register model checked every falling edge, plus directed literal checks.
module tb_mmio_gpio_bank;

  localparam int XLEN = 32;
  localparam int NI   = 14;
  localparam int NO   = 52;
  localparam int BASE = 'h15;
  localparam int NOUT = 2;
  localparam int NIN  = 1;
  localparam int WIN  = NOUT + 3 * NIN;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [XLEN-1:0] addr  = '0;
  logic [XLEN-1:0] wdata = '0;
  logic            wen   = 1'b0;
  logic            ren   = 1'b0;
  logic [XLEN-1:0] rdata;
  logic            hit;
  logic [NI-1:0]   io_input_bus = '0;
  logic [NO-1:0]   io_output_bus;
  logic            irq;

  int vectors     = 0;
  int miscompares = 0;

  mmio_gpio_bank #(
    .XLEN(XLEN), .IO_INPUT_BUS_LEN(NI), .IO_OUTPUT_BUS_LEN(NO), .IO_BASE_ADDR(BASE)
  ) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .wen(wen), .ren(ren),
    .rdata(rdata), .hit(hit), .io_input_bus(io_input_bus),
    .io_output_bus(io_output_bus), .irq(irq)
  );

  always #5 clock = ~clock;

  // Model: register words plus the pin value as sampled 1, 2 and 3 edges ago.
  logic [31:0] m_out  [NOUT];
  logic [31:0] m_mask [NIN];
  logic [31:0] m_cap  [NIN];
  logic [NI-1:0] h1, h2, h3;

  function automatic logic [31:0] valid_bits(int pins, int k);
    int n = pins - k * 32;
    if (n >= 32) return 32'hFFFF_FFFF;
    if (n <= 0) return 32'h0;
    return (32'h1 << n) - 32'h1;
  endfunction

  function automatic logic [31:0] pin_word(logic [NI-1:0] v, int k);
    logic [NIN*32-1:0] w;
    w = '0;
    w[NI-1:0] = v;
    return w[k*32 +: 32];
  endfunction

  function automatic int offset_of(logic [31:0] a);
    if (a < 32'(BASE) || a >= 32'(BASE + WIN)) return -1;
    return int'(a - 32'(BASE));
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NOUT; k++) m_out[k] <= '0;
      for (int k = 0; k < NIN; k++) begin
        m_mask[k] <= '0;
        m_cap[k]  <= '0;
      end
      h1 <= '0;
      h2 <= '0;
      h3 <= '0;
    end else begin
      for (int k = 0; k < NOUT; k++)
        if (wen && offset_of(addr) == k) m_out[k] <= wdata & valid_bits(NO, k);
      for (int k = 0; k < NIN; k++) begin
        if (wen && offset_of(addr) == NOUT + 2 * NIN + k)
          m_mask[k] <= wdata & valid_bits(NI, k);
        m_cap[k] <= (m_cap[k] & ~((wen && offset_of(addr) == NOUT + NIN + k) ? wdata : 32'h0))
                    | pin_word(h2 & ~h3, k);
      end
      h1 <= io_input_bus;
      h2 <= h1;
      h3 <= h2;
    end
  end

  function automatic logic [31:0] model_read(logic [31:0] a, logic r);
    int o = offset_of(a);
    if (!r || o < 0) return 32'h0;
    if (o < NOUT) return m_out[o];
    if (o < NOUT + NIN) return pin_word(h2, o - NOUT);
    if (o < NOUT + 2 * NIN) return m_cap[o - NOUT - NIN];
    return m_mask[o - NOUT - 2 * NIN];
  endfunction

  function automatic logic model_irq();
    logic any = 1'b0;
    for (int k = 0; k < NIN; k++) any = any | (|(m_cap[k] & m_mask[k]));
    return any;
  endfunction

  function automatic logic [NO-1:0] model_bus();
    logic [NOUT*32-1:0] w;
    for (int k = 0; k < NOUT; k++) w[k*32 +: 32] = m_out[k];
    return w[NO-1:0];
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    check("model_bus", 64'(io_output_bus), 64'(model_bus()));
    check("model_irq", 64'(irq), 64'(model_irq()));
    check("model_hit", 64'(hit), 64'(offset_of(addr) >= 0));
    check("model_rdata", 64'(rdata), 64'(model_read(addr, ren)));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    ren   = 1'b0;
    step();
    wen   = 1'b0;
  endtask

  task automatic rd(string name, logic [31:0] a, logic [31:0] exp);
    addr = a;
    ren  = 1'b1;
    #1;
    check(name, 64'(rdata), 64'(exp));
  endtask

  initial begin
    repeat (2) step();
    check("rst_bus", 64'(io_output_bus), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    rd("rst_out0", 32'h15, 32'h0);
    reset = 1'b0;
    step();

    // Output words, padding bits of the upper word
    wr(32'h15, 32'hDEADBEEF);
    wr(32'h16, 32'h000FFFFF);
    check("out_bus", 64'(io_output_bus), 64'h000F_FFFF_DEAD_BEEF);
    rd("out1", 32'h16, 32'h000FFFFF);
    rd("out0", 32'h15, 32'hDEADBEEF);
    check("hit_out", 64'(hit), 64'h1);
    wr(32'h16, 32'hFFFFFFFF);
    rd("out1_pad", 32'h16, 32'h000FFFFF);
    check("out_bus_pad", 64'(io_output_bus), 64'h000F_FFFF_DEAD_BEEF);

    // Input synchronizer latency and read-only IN
    io_input_bus = 14'h2A5;
    rd("in_e0", 32'h17, 32'h0);
    step();
    rd("in_e1", 32'h17, 32'h0);
    step();
    rd("in_e2", 32'h17, 32'h2A5);
    wr(32'h17, 32'hFFFF);
    rd("in_ro", 32'h17, 32'h2A5);
    rd("cap_2a5", 32'h18, 32'h2A5);
    check("irq_unmasked", 64'(irq), 64'h0);
    wr(32'h18, 32'hFFFFFFFF);
    rd("cap_clr_level", 32'h18, 32'h0);
    io_input_bus = 14'h0;
    repeat (4) step();
    rd("cap_fall", 32'h18, 32'h0);

    // Masked capture, W1C, unmasked pin
    wr(32'h19, 32'h1);
    rd("mask", 32'h19, 32'h1);
    io_input_bus = 14'h1;
    step();
    step();
    rd("cap_e2", 32'h18, 32'h0);
    check("irq_e2", 64'(irq), 64'h0);
    step();
    rd("cap_e3", 32'h18, 32'h1);
    check("irq_e3", 64'(irq), 64'h1);
    wr(32'h18, 32'h1);
    rd("cap_w1c", 32'h18, 32'h0);
    check("irq_w1c", 64'(irq), 64'h0);
    io_input_bus = 14'h3;
    repeat (3) step();
    rd("cap_pin1", 32'h18, 32'h2);
    check("irq_masked_out", 64'(irq), 64'h0);

    // Rise and W1C on the same edge
    wr(32'h18, 32'h3);
    io_input_bus = 14'h2;
    repeat (3) step();
    io_input_bus = 14'h3;
    step();
    step();
    wr(32'h18, 32'h1);
    rd("cap_set_wins", 32'h18, 32'h1);
    check("irq_set_wins", 64'(irq), 64'h1);

    // Just outside the window
    rd("miss_lo", 32'h14, 32'h0);
    check("hit_lo", 64'(hit), 64'h0);
    rd("miss_hi", 32'h1A, 32'h0);
    check("hit_hi", 64'(hit), 64'h0);
    wr(32'h14, 32'hFFFFFFFF);
    wr(32'h1A, 32'hFFFFFFFF);
    check("miss_bus", 64'(io_output_bus), 64'h000F_FFFF_DEAD_BEEF);
    rd("mask_keep", 32'h19, 32'h1);
    rd("cap_keep", 32'h18, 32'h1);

    // Asynchronous reset mid-cycle, write during reset, inputs held high after release
    reset = 1'b1;
    #1;
    check("arst_bus", 64'(io_output_bus), 64'h0);
    check("arst_irq", 64'(irq), 64'h0);
    addr  = 32'h15;
    wdata = 32'h1234;
    wen   = 1'b1;
    step();
    wen   = 1'b0;
    check("rst_write", 64'(io_output_bus), 64'h0);
    reset = 1'b0;
    rd("rel_out0", 32'h15, 32'h0);
    rd("rel_out1", 32'h16, 32'h0);
    rd("rel_in", 32'h17, 32'h0);
    step();
    rd("rel_cap", 32'h18, 32'h0);
    rd("rel_mask", 32'h19, 32'h0);
    rd("rel_in_e1", 32'h17, 32'h0);
    step();
    rd("rel_in_e2", 32'h17, 32'h3);
    rd("rel_cap_e2", 32'h18, 32'h0);
    step();
    rd("rel_cap_e3", 32'h18, 32'h3);
    check("rel_irq", 64'(irq), 64'h0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
